// File: rtl/sha256_host_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | sha256_host_pkg : shared types and constants for the SHA-256 host ctrl   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
package sha256_host_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    RD_REQ    = 3'd4,
    RD_WAIT   = 3'd5,
    OUT       = 3'd6
  } state_e;

  localparam int HASH_WORDS             = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

endpackage
`default_nettype wire

// File: rtl/sha256_host_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | sha256_host_ctrl_if : host stream, hasher handshake and SRAM port bundle  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
interface sha256_host_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              go;
  logic [ADDR_W-1:0] message_addr;
  logic [ADDR_W-1:0] output_addr;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              error;
  logic              sha_start;
  logic [ADDR_W-1:0] sha_message_addr;
  logic [ADDR_W-1:0] sha_output_addr;
  logic              sha_done;
  logic              mem_sel_sha;
  logic              mem_clk;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    input  go, message_addr, output_addr, in_valid, in_data, out_ready,
           sha_done, mem_read_data,
    output in_ready, out_valid, out_data, out_last, busy, error, sha_start,
           sha_message_addr, sha_output_addr, mem_sel_sha, mem_clk, mem_we,
           mem_addr, mem_write_data
  );

  modport slave (
    output go, message_addr, output_addr, in_valid, in_data, out_ready,
           sha_done, mem_read_data,
    input  in_ready, out_valid, out_data, out_last, busy, error, sha_start,
           sha_message_addr, sha_output_addr, mem_sel_sha, mem_clk, mem_we,
           mem_addr, mem_write_data
  );
endinterface
`default_nettype wire

// File: rtl/sha256_host_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | sha256_host_ctrl : loads message words to SRAM, runs the hasher, streams  |
// | the digest back out.                          Revision 1.0                |
// +--------------------------------------------------------------------------+
module sha256_host_ctrl
  import sha256_host_pkg::*;
#(
  parameter int NUM_OF_WORDS   = 20,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               reset_n,
  sha256_host_ctrl_if.master bus
);

  localparam int MAX_WORDS = (NUM_OF_WORDS > HASH_WORDS) ? NUM_OF_WORDS : HASH_WORDS;
  localparam int IDX_W     = $clog2(MAX_WORDS);
  localparam int TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IN  = IDX_W'(NUM_OF_WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_OUT = IDX_W'(HASH_WORDS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [ADDR_W-1:0] msg_base_q, msg_base_d;
  logic [ADDR_W-1:0] out_base_q, out_base_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              error_q, error_d;
  logic              sha_start_q, sha_start_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_sel_q, mem_sel_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tmo_q       <= '0;
      msg_base_q  <= '0;
      out_base_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      error_q     <= 1'b0;
      sha_start_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      msg_base_q  <= msg_base_d;
      out_base_q  <= out_base_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      error_q     <= error_d;
      sha_start_q <= sha_start_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_sel_q   <= mem_sel_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    msg_base_d  = msg_base_q;
    out_base_d  = out_base_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    error_d     = error_q;
    sha_start_d = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_sel_d   = mem_sel_q;

    case (state_q)
      IDLE: begin
        if (bus.go) begin
          msg_base_d = bus.message_addr;
          out_base_d = bus.output_addr;
          error_d    = 1'b0;
          idx_d      = '0;
          in_ready_d = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        // in_ready low here means the final word's write is on the bus now
        if (in_ready_q) begin
          if (bus.in_valid) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = msg_base_q + ADDR_W'(idx_q);
            mem_wdata_d = bus.in_data;
            if (idx_q == LAST_IN) begin
              in_ready_d = 1'b0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end else begin
          sha_start_d = 1'b1;
          mem_sel_d   = 1'b1;
          state_d     = START;
        end
      end
      START: begin
        tmo_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.sha_done) begin
          mem_sel_d  = 1'b0;
          idx_d      = '0;
          mem_addr_d = out_base_q;
          state_d    = RD_REQ;
        end else if (tmo_q == TMO_LAST) begin
          error_d   = 1'b1;
          mem_sel_d = 1'b0;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RD_REQ: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        out_data_d  = bus.mem_read_data;
        out_valid_d = 1'b1;
        out_last_d  = (idx_q == LAST_OUT);
        state_d     = OUT;
      end
      OUT: begin
        // address for the next word is issued together with leaving OUT
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (idx_q == LAST_OUT) begin
            state_d = IDLE;
          end else begin
            idx_d      = idx_q + 1'b1;
            mem_addr_d = out_base_q + ADDR_W'(idx_q) + ADDR_W'(1);
            state_d    = RD_REQ;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready         = in_ready_q;
  assign bus.out_valid        = out_valid_q;
  assign bus.out_data         = out_data_q;
  assign bus.out_last         = out_last_q;
  assign bus.busy             = (state_q != IDLE);
  assign bus.error            = error_q;
  assign bus.sha_start        = sha_start_q;
  assign bus.sha_message_addr = msg_base_q;
  assign bus.sha_output_addr  = out_base_q;
  assign bus.mem_sel_sha      = mem_sel_q;
  assign bus.mem_clk          = clk;
  assign bus.mem_we           = mem_we_q;
  assign bus.mem_addr         = mem_addr_q;
  assign bus.mem_write_data   = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_host_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sha256_host_ctrl : randomized bench with SRAM + SHA-256 hasher model   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_sha256_host_ctrl;

  localparam int NW  = 20;
  localparam int TMO = 64;

  typedef logic [NW-1:0][31:0] msg_t;
  typedef logic [7:0][31:0]    dig_t;
  typedef struct packed { logic [15:0] a; logic [31:0] d; } wr_t;

  localparam logic [31:0] H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sha256_host_ctrl_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  sha256_host_ctrl #(
    .NUM_OF_WORDS(NW), .ADDR_W(16), .DATA_W(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Full SHA-256 of the NW-word message: padding, two 512-bit blocks
  function automatic dig_t sha256_msg(input msg_t m);
    logic [31:0] blk [32];
    logic [31:0] w [64];
    logic [31:0] h [8];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    dig_t d;
    for (int i = 0; i < 32; i++) blk[i] = 32'h0;
    for (int i = 0; i < NW; i++) blk[i] = m[i];
    blk[NW] = 32'h8000_0000;
    blk[31] = 32'(NW * 32);
    for (int i = 0; i < 8; i++) h[i] = H0[i];
    for (int b = 0; b < 2; b++) begin
      for (int t = 0; t < 64; t++) begin
        if (t < 16) w[t] = blk[b*16 + t];
        else w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                  + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      end
      for (int i = 0; i < 8; i++) v[i] = h[i];
      for (int t = 0; t < 64; t++) begin
        t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
        t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        for (int j = 7; j > 0; j--) v[j] = v[j-1];
        v[4] = v[4] + t1;
        v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) h[i] = h[i] + v[i];
    end
    for (int i = 0; i < 8; i++) d[i] = h[i];
    return d;
  endfunction

  // SRAM + hasher model
  logic [31:0] sram [0:65535];
  wr_t         wlog [$];
  int          n_start   = 0;
  int          bad_we    = 0;
  int          cyc       = 0;
  int          hcount    = 0;
  bit          hasher_en = 1'b1;

  function automatic logic [31:0] hash_word(input logic [15:0] base, input int i);
    msg_t m;
    dig_t d;
    logic [15:0] a;
    for (int k = 0; k < NW; k++) begin
      a = base + 16'(k);
      m[k] = sram[a];
    end
    d = sha256_msg(m);
    return d[i];
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.mem_read_data <= sram[bus.mem_addr];
    bus.sha_done <= 1'b0;
    if (bus.mem_we) begin
      if (bus.mem_sel_sha) bad_we <= bad_we + 1;
      else begin
        sram[bus.mem_addr] <= bus.mem_write_data;
        wlog.push_back({bus.mem_addr, bus.mem_write_data});
      end
    end
    if (hcount == 1) begin
      for (int i = 0; i < 8; i++) sram[bus.sha_output_addr + 16'(i)] <= hash_word(bus.sha_message_addr, i);
      bus.sha_done <= 1'b1;
    end
    if (hcount != 0) hcount <= hcount - 1;
    if (bus.sha_start) begin
      n_start <= n_start + 1;
      if (hasher_en) hcount <= 5;
    end
  end

  function automatic msg_t rand_msg();
    msg_t m;
    for (int i = 0; i < NW; i++) m[i] = $urandom;
    return m;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_last"}, bus.out_last, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_error"}, bus.error, 0);
    chk({tag, "_sha_start"}, bus.sha_start, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_write_data, 0);
    chk({tag, "_mem_sel"}, bus.mem_sel_sha, 0);
  endtask

  task automatic start_run(input logic [15:0] m, input logic [15:0] o);
    @(negedge clk);
    bus.go = 1'b1;
    bus.message_addr = m;
    bus.output_addr = o;
    @(negedge clk);
    bus.go = 1'b0;
    bus.message_addr = 16'($urandom);
    bus.output_addr = 16'($urandom);
    chk("go_busy", bus.busy, 1);
    chk("go_in_ready", bus.in_ready, 1);
    chk("go_error_clr", bus.error, 0);
    chk("go_msg_addr", bus.sha_message_addr, m);
    chk("go_out_addr", bus.sha_output_addr, o);
  endtask

  // Random in_valid gaps; random go/address noise must not disturb the run
  task automatic load_words(input msg_t w, input int stop_at);
    int k = 0;
    int g = 0;
    while (k < stop_at && g < 2000) begin
      @(negedge clk);
      g++;
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data = bus.in_valid ? w[k] : $urandom;
      bus.go = 1'($urandom_range(0, 1));
      bus.message_addr = 16'($urandom);
      if (bus.in_valid && bus.in_ready) k++;
    end
    if (k != stop_at) chk("load_timeout", k, stop_at);
  endtask

  task automatic check_writes(input int ws, input logic [15:0] base, input msg_t w);
    logic [15:0] ea;
    chk("wr_count", wlog.size() - ws, NW);
    for (int i = 0; i < NW; i++) begin
      if (ws + i < wlog.size()) begin
        ea = base + 16'(i);
        chk("wr_addr", wlog[ws+i].a, ea);
        chk("wr_data", wlog[ws+i].d, w[i]);
      end
    end
  endtask

  task automatic read_digest(input dig_t exp, input bit stall);
    int i = 0;
    int g = 0;
    int last_cyc = 0;
    logic [31:0] hold_d;
    logic [15:0] hold_a;
    bus.out_ready = 1'b1;
    while (i < 8 && g < 500) begin
      @(negedge clk);
      g++;
      if (bus.out_valid) begin
        chk("out_data", bus.out_data, exp[i]);
        chk("out_last", bus.out_last, (i == 7));
        if (i == 1 || i == 2) chk("throughput", cyc - last_cyc, 3);
        last_cyc = cyc;
        if (stall && i == 3) begin
          bus.out_ready = 1'b0;
          hold_d = bus.out_data;
          hold_a = bus.mem_addr;
          repeat (10) begin
            @(negedge clk);
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_data", bus.out_data, hold_d);
            chk("stall_addr", bus.mem_addr, hold_a);
          end
          bus.out_ready = 1'b1;
        end
        i++;
      end
    end
    if (i < 8) chk("digest_timeout", i, 8);
    @(negedge clk);
    chk("end_busy", bus.busy, 0);
    chk("end_valid", bus.out_valid, 0);
  endtask

  task automatic full_run(input msg_t w, input logic [15:0] m, input logic [15:0] o, input bit stall);
    int ws;
    int s0;
    s0 = n_start;
    start_run(m, o);
    ws = wlog.size();
    load_words(w, NW);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.go = 1'b0;
    chk("ready_drop", bus.in_ready, 0);
    read_digest(sha256_msg(w), stall);
    check_writes(ws, m, w);
    chk("start_pulses", n_start - s0, 1);
    chk("hold_msg_addr", bus.sha_message_addr, m);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    msg_t w;
    int ws;
    int s0;
    int cnt;
    int g;
    bit seen;

    bus.go = 1'b0;
    bus.message_addr = '0;
    bus.output_addr = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;

    // in_valid in IDLE must not produce writes
    bus.in_valid = 1'b1;
    bus.in_data = 32'hdead_beef;
    repeat (4) @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("idle_in_ready", bus.in_ready, 0);
    chk("idle_writes", wlog.size(), 0);
    bus.in_valid = 1'b0;

    // Reference message: rotate-left-by-one chain, last word zero
    w[0] = 32'h0123_4567;
    for (int i = 1; i < NW - 1; i++) w[i] = {w[i-1][30:0], w[i-1][31]};
    w[NW-1] = 32'h0;
    full_run(w, 16'd0, 16'd1000, 1'b1);

    // Hasher silent: timeout path
    hasher_en = 1'b0;
    w = rand_msg();
    s0 = n_start;
    start_run(16'h0200, 16'h0300);
    ws = wlog.size();
    load_words(w, NW);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.go = 1'b0;
    cnt = 0;
    g = 0;
    seen = 1'b0;
    while (g < 300) begin
      if (seen) begin
        if (bus.busy) cnt++;
        else break;
      end else if (bus.sha_start) begin
        seen = 1'b1;
      end
      @(negedge clk);
      g++;
    end
    chk("tmo_wait_cycles", cnt, TMO);
    chk("tmo_error", bus.error, 1);
    chk("tmo_busy", bus.busy, 0);
    chk("tmo_mem_sel", bus.mem_sel_sha, 0);
    chk("tmo_start_pulses", n_start - s0, 1);
    check_writes(ws, 16'h0200, w);
    repeat (3) @(negedge clk);
    chk("tmo_error_sticky", bus.error, 1);
    hasher_en = 1'b1;
    full_run(rand_msg(), 16'h4000, 16'h5000, 1'b0);

    // Reset in the middle of LOAD
    w = rand_msg();
    start_run(16'h0100, 16'h0200);
    load_words(w, 10);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.go = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    ws = wlog.size();
    bus.in_valid = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("post_rst_writes", wlog.size() - ws, 0);
    chk("post_rst_busy", bus.busy, 0);
    full_run(rand_msg(), 16'h0100, 16'h0200, 1'b0);

    // Address wrap on both regions
    full_run(rand_msg(), 16'hFFF8, 16'hFFFC, 1'b1);

    chk("no_write_while_hasher", bad_we, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
